// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter from NUM_PORTS requesters onto one block-wide memory port.
// Optional watchdog abort enabled by defining ARB_TIMEOUT_EN.
module mem_rr_arbiter #(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_W      = 32,
    parameter int BLK_W       = 128,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_PORTS-1:0]      req_valid_i,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_PORTS-1:0]      req_we_i,
    input  logic [NUM_PORTS*2-1:0]    req_size_i,
    input  logic [NUM_PORTS*BLK_W-1:0] req_wdata_i,
    output logic [NUM_PORTS-1:0]      req_gnt_o,
    output logic [NUM_PORTS-1:0]      res_valid_o,
    output logic                      res_err_o,
    output logic [BLK_W-1:0]          res_rdata_o,
    output logic                      mem_valid_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [BLK_W/8-1:0]        mem_wstrb_o,
    output logic [BLK_W-1:0]          mem_wdata_o,
    input  logic                      mem_ready_i,
    input  logic [BLK_W-1:0]          mem_rdata_i
);

    localparam int PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int SW   = BLK_W / 8;
    localparam int BOFF = $clog2(SW);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]        state;
    logic [PW-1:0]     owner;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     sel;
    logic [PW-1:0]     next_ptr;
    logic [PW:0]       sum;
    logic              found;
    logic              busy;
    logic              done;
    logic              abort;
    logic              finish;
    int                oi;
    logic [ADDR_W-1:0] own_addr;
    logic [1:0]        own_size;
    logic              own_we;
    logic [BOFF-1:0]   off;
    logic [SW-1:0]     strb;

    assign busy = (state == S_BUSY);
    assign done = busy && mem_ready_i;

    // Scan from rr_ptr upward, wrapping, and take the first requester.
    always_comb begin
        sel   = rr_ptr;
        found = 1'b0;
        sum   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            sum = {1'b0, rr_ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(NUM_PORTS))
                sum = sum - (PW+1)'(NUM_PORTS);
            if (!found && req_valid_i[sum[PW-1:0]]) begin
                found = 1'b1;
                sel   = sum[PW-1:0];
            end
        end
    end

    assign oi       = int'(owner);
    assign own_addr = req_addr_i[oi*ADDR_W +: ADDR_W];
    assign own_size = req_size_i[oi*2 +: 2];
    assign own_we   = req_we_i[owner];
    assign off      = own_addr[BOFF-1:0];

    always_comb begin
        strb = '0;
        if (busy && own_we) begin
            case (own_size)
                2'b01:   strb = SW'(1) << off;
                2'b10:   strb = SW'(3) << off;
                2'b11:   strb = '1;
                default: strb = '0;
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC) + 1;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt <= '0;
        else if (!busy)
            cnt <= '0;
        else if (!mem_ready_i)
            cnt <= cnt + CW'(1);
    end

    // A ready arriving on the expiry cycle wins over the abort.
    assign abort     = busy && !mem_ready_i && (cnt == CW'(TIMEOUT_CYC - 1));
    assign res_err_o = abort;
`else
    assign abort     = 1'b0;
    assign res_err_o = 1'b0;
`endif

    assign finish   = done || abort;
    assign next_ptr = (owner == PW'(NUM_PORTS - 1)) ? '0 : owner + PW'(1);

    assign req_gnt_o   = (!busy && found && !rst_i) ? (NUM_PORTS'(1) << sel) : '0;
    assign res_valid_o = finish ? (NUM_PORTS'(1) << owner) : '0;
    assign res_rdata_o = mem_rdata_i;
    assign mem_valid_o = busy;
    assign mem_addr_o  = own_addr;
    assign mem_wstrb_o = strb;
    assign mem_wdata_o = req_wdata_i[oi*BLK_W +: BLK_W];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= S_IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        owner <= sel;
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (finish) begin
                        rr_ptr <= next_ptr;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Scoreboard bench for mem_rr_arbiter with three ports and 128-bit blocks.
// Watchdog scenario is exercised when ARB_TIMEOUT_EN is defined.
module tb_mem_rr_arbiter;

    localparam int NP = 3;
    localparam int AW = 32;
    localparam int BW = 128;
    localparam int SW = 16;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     req_valid;
    logic [NP*AW-1:0]  req_addr;
    logic [NP-1:0]     req_we;
    logic [NP*2-1:0]   req_size;
    logic [NP*BW-1:0]  req_wdata;
    logic [NP-1:0]     req_gnt;
    logic [NP-1:0]     res_valid;
    logic              res_err;
    logic [BW-1:0]     res_rdata;
    logic              mem_valid;
    logic [AW-1:0]     mem_addr;
    logic [SW-1:0]     mem_wstrb;
    logic [BW-1:0]     mem_wdata;
    logic              mem_ready;
    logic [BW-1:0]     mem_rdata;

    typedef struct {
        int          port;
        logic [BW-1:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;

    mem_rr_arbiter #(
        .NUM_PORTS(NP), .ADDR_W(AW), .BLK_W(BW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_addr_i(req_addr), .req_we_i(req_we),
        .req_size_i(req_size), .req_wdata_i(req_wdata),
        .req_gnt_o(req_gnt), .res_valid_o(res_valid), .res_err_o(res_err),
        .res_rdata_o(res_rdata), .mem_valid_o(mem_valid), .mem_addr_o(mem_addr),
        .mem_wstrb_o(mem_wstrb), .mem_wdata_o(mem_wdata),
        .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic set_port(input int p, input logic [AW-1:0] a, input logic we,
                            input logic [1:0] sz, input logic [BW-1:0] wd);
        req_addr[p*AW +: AW]  = a;
        req_we[p]             = we;
        req_size[p*2 +: 2]    = sz;
        req_wdata[p*BW +: BW] = wd;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req_valid = '0;
        mem_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        logic [BW-1:0] d;
        rst = 1'b1;
        req_valid = 3'b111;
        req_addr = '0; req_we = '0; req_size = '0; req_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        #1;
        checks++;
        if ({mem_valid, mem_wstrb, req_gnt, res_valid, res_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got gnt=%b mv=%b strb=%h rv=%b err=%b expected all 0",
                     req_gnt, mem_valid, mem_wstrb, res_valid, res_err);
        end
        tick();
        rst = 1'b0; req_valid = '0;
        tick();
        d = {4{32'h1111_0000}};
        set_port(0, 32'h0000_0040, 1'b0, 2'b11, '0);
        set_port(1, 32'h0000_0080, 1'b0, 2'b11, '0);
        req_valid = 3'b001;
        settle();
        checks++;
        if (req_gnt !== 3'b001) begin
            failures++;
            $display("FAIL reset_first_gnt: got %b expected 001", req_gnt);
        end
        sb.push_back('{port: 0, data: d, err: 1'b0});
        tick();
        mem_ready = 1'b1; mem_rdata = d;
        settle();
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL reset_rsp0: response with empty scoreboard");
        end else begin
            e = sb.pop_front();
            if ({res_valid, res_err, res_rdata} !== {3'b1 << e.port, e.err, e.data}) begin
                failures++;
                $display("FAIL reset_rsp0: got rv=%b err=%b data=%h expected port %0d err=%b data=%h",
                         res_valid, res_err, res_rdata, e.port, e.err, e.data);
            end
        end
        tick();
        mem_ready = 1'b0;
        req_valid = 3'b011;
        settle();
        checks++;
        if (req_gnt !== 3'b010) begin
            failures++;
            $display("FAIL rr_advance: got %b expected 010", req_gnt);
        end
        tick();
        settle();
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_valid, mem_wstrb, req_gnt, res_valid, res_err} !== '0) begin
            failures++;
            $display("FAIL reset_mid_busy: got gnt=%b mv=%b strb=%h rv=%b err=%b expected all 0",
                     req_gnt, mem_valid, mem_wstrb, res_valid, res_err);
        end
        tick();
        rst = 1'b0;
        settle();
        checks++;
        if (req_gnt !== 3'b001) begin
            failures++;
            $display("FAIL reset_rr_ptr: got gnt %b expected 001", req_gnt);
        end
        sb.push_back('{port: 0, data: d, err: 1'b0});
        tick();
        mem_ready = 1'b1;
        settle();
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL reset_rsp1: response with empty scoreboard");
        end else begin
            e = sb.pop_front();
            if ({res_valid, res_err, res_rdata} !== {3'b1 << e.port, e.err, e.data}) begin
                failures++;
                $display("FAIL reset_rsp1: got rv=%b err=%b data=%h expected port %0d",
                         res_valid, res_err, res_rdata, e.port);
            end
        end
        tick();
        mem_ready = 1'b0; req_valid = '0;
    endtask

    task automatic test_single_read;
        logic [BW-1:0] d;
        do_reset();
        d = {16{8'hA5}};
        set_port(0, 32'h0000_1000, 1'b0, 2'b11, '0);
        req_valid = 3'b001;
        settle();
        checks++;
        if ({req_gnt, mem_valid} !== {3'b001, 1'b0}) begin
            failures++;
            $display("FAIL single_gnt: got gnt=%b mv=%b expected 001/0", req_gnt, mem_valid);
        end
        sb.push_back('{port: 0, data: d, err: 1'b0});
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 2) begin
                mem_ready = 1'b1; mem_rdata = d;
            end
            settle();
            checks++;
            if ({mem_valid, mem_addr, mem_wstrb} !== {1'b1, 32'h0000_1000, 16'h0000}) begin
                failures++;
                $display("FAIL single_busy%0d: got mv=%b addr=%h strb=%h expected 1/00001000/0000",
                         k, mem_valid, mem_addr, mem_wstrb);
            end
            if (k < 2) begin
                checks++;
                if (res_valid !== 3'b000) begin
                    failures++;
                    $display("FAIL single_early_rsp%0d: got %b expected 000", k, res_valid);
                end
            end else begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL single_rsp: response with empty scoreboard");
                end else begin
                    e = sb.pop_front();
                    if ({res_valid, res_err, res_rdata} !== {3'b1 << e.port, e.err, e.data}) begin
                        failures++;
                        $display("FAIL single_rsp: got rv=%b err=%b data=%h expected port %0d data=%h",
                                 res_valid, res_err, res_rdata, e.port, e.data);
                    end
                end
            end
        end
        tick();
        req_valid = '0; mem_ready = 1'b0;
        settle();
        checks++;
        if ({mem_valid, res_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL single_idle: got mv=%b rv=%b expected 0/000", mem_valid, res_valid);
        end
    endtask

    task automatic test_contention;
        logic [BW-1:0] dat [6];
        int            ep;
        do_reset();
        for (int p = 0; p < NP; p++)
            set_port(p, 32'h0000_2000 + 32'(p) * 32'h100, 1'b0, 2'b11, '0);
        for (int t = 0; t < 6; t++) begin
            dat[t] = {$urandom, $urandom, $urandom, $urandom};
            sb.push_back('{port: t % NP, data: dat[t], err: 1'b0});
        end
        req_valid = 3'b111;
        for (int t = 0; t < 6; t++) begin
            ep = t % NP;
            settle();
            checks++;
            if (req_gnt !== (3'b1 << ep)) begin
                failures++;
                $display("FAIL contend_gnt%0d: got %b expected port %0d", t, req_gnt, ep);
            end
            tick();
            mem_ready = 1'b1; mem_rdata = dat[t];
            settle();
            checks++;
            if (mem_addr !== 32'h0000_2000 + 32'(ep) * 32'h100) begin
                failures++;
                $display("FAIL contend_addr%0d: got %h expected port %0d lane", t, mem_addr, ep);
            end
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL contend_rsp%0d: response with empty scoreboard", t);
            end else begin
                e = sb.pop_front();
                if ({res_valid, res_err, res_rdata} !== {3'b1 << e.port, e.err, e.data}) begin
                    failures++;
                    $display("FAIL contend_rsp%0d: got rv=%b err=%b data=%h expected port %0d data=%h",
                             t, res_valid, res_err, res_rdata, e.port, e.data);
                end
            end
            tick();
            mem_ready = 1'b0;
        end
        req_valid = '0;
    endtask

    task automatic test_strobes;
        logic [AW-1:0] ta [8];
        logic [1:0]    ts [8];
        logic          tw [8];
        logic [SW-1:0] tx [8];
        logic [BW-1:0] wd;
        logic [BW-1:0] rd;
        int            p;
        ta = '{32'h107, 32'h10E, 32'h10F, 32'h100, 32'h107, 32'h100, 32'h105, 32'h102};
        ts = '{2'b01,   2'b10,   2'b10,   2'b11,   2'b11,   2'b01,   2'b00,   2'b10};
        tw = '{1'b1,    1'b1,    1'b1,    1'b1,    1'b0,    1'b1,    1'b1,    1'b1};
        tx = '{16'h0080, 16'hC000, 16'h8000, 16'hFFFF, 16'h0000, 16'h0001, 16'h0000, 16'h000C};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            p  = i % NP;
            wd = {$urandom, $urandom, $urandom, $urandom};
            rd = {$urandom, $urandom, $urandom, $urandom};
            set_port(p, ta[i], tw[i], ts[i], wd);
            req_valid = NP'(1) << p;
            sb.push_back('{port: p, data: rd, err: 1'b0});
            settle();
            checks++;
            if (req_gnt !== (3'b1 << p)) begin
                failures++;
                $display("FAIL strb_gnt%0d: got %b expected port %0d", i, req_gnt, p);
            end
            tick();
            mem_ready = 1'b1; mem_rdata = rd;
            settle();
            checks++;
            if ({mem_wstrb, mem_wdata} !== {tx[i], wd}) begin
                failures++;
                $display("FAIL strb%0d: got strb=%h wdata=%h expected strb=%h wdata=%h",
                         i, mem_wstrb, mem_wdata, tx[i], wd);
            end
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL strb_rsp%0d: response with empty scoreboard", i);
            end else begin
                e = sb.pop_front();
                if ({res_valid, res_err, res_rdata} !== {3'b1 << e.port, e.err, e.data}) begin
                    failures++;
                    $display("FAIL strb_rsp%0d: got rv=%b err=%b expected port %0d",
                             i, res_valid, res_err, e.port);
                end
            end
            tick();
            req_valid = '0; mem_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back;
        logic [BW-1:0] d0;
        logic [BW-1:0] d1;
        logic [BW-1:0] w0;
        do_reset();
        d0 = {4{32'hC0DE_0000}};
        d1 = {4{32'hBEEF_0001}};
        w0 = {4{32'h1234_5678}};
        mem_ready = 1'b1;
        settle();
        checks++;
        if ({res_valid, mem_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL idle_ready: got rv=%b mv=%b expected 000/0", res_valid, mem_valid);
        end
        tick();
        mem_ready = 1'b0;
        set_port(1, 32'h0000_3000, 1'b0, 2'b11, '0);
        set_port(0, 32'h0000_4000, 1'b1, 2'b11, w0);
        req_valid = 3'b010;
        sb.push_back('{port: 1, data: d1, err: 1'b0});
        settle();
        checks++;
        if (req_gnt !== 3'b010) begin
            failures++;
            $display("FAIL b2b_gnt1: got %b expected 010", req_gnt);
        end
        tick();
        req_valid = 3'b011;
        settle();
        checks++;
        if ({req_gnt, mem_addr} !== {3'b000, 32'h0000_3000}) begin
            failures++;
            $display("FAIL b2b_no_preempt: got gnt=%b addr=%h expected 000/00003000", req_gnt, mem_addr);
        end
        tick();
        mem_ready = 1'b1; mem_rdata = d1;
        settle();
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL b2b_rsp1: response with empty scoreboard");
        end else begin
            e = sb.pop_front();
            if ({res_valid, res_err, res_rdata} !== {3'b1 << e.port, e.err, e.data}) begin
                failures++;
                $display("FAIL b2b_rsp1: got rv=%b err=%b data=%h expected port %0d",
                         res_valid, res_err, res_rdata, e.port);
            end
        end
        tick();
        mem_ready = 1'b0; req_valid = 3'b001;
        settle();
        checks++;
        if ({req_gnt, mem_valid} !== {3'b001, 1'b0}) begin
            failures++;
            $display("FAIL b2b_gnt0: got gnt=%b mv=%b expected 001/0", req_gnt, mem_valid);
        end
        sb.push_back('{port: 0, data: d0, err: 1'b0});
        tick();
        settle();
        checks++;
        if ({mem_valid, mem_addr, mem_wstrb, mem_wdata} !== {1'b1, 32'h0000_4000, 16'hFFFF, w0}) begin
            failures++;
            $display("FAIL b2b_issue0: got mv=%b addr=%h strb=%h expected 1/00004000/ffff",
                     mem_valid, mem_addr, mem_wstrb);
        end
        mem_ready = 1'b1; mem_rdata = d0;
        settle();
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL b2b_rsp0: response with empty scoreboard");
        end else begin
            e = sb.pop_front();
            if ({res_valid, res_err, res_rdata} !== {3'b1 << e.port, e.err, e.data}) begin
                failures++;
                $display("FAIL b2b_rsp0: got rv=%b err=%b data=%h expected port %0d",
                         res_valid, res_err, res_rdata, e.port);
            end
        end
        tick();
        mem_ready = 1'b0; req_valid = '0;
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout;
        logic [BW-1:0] d;
        do_reset();
        d = {4{32'h0BAD_F00D}};
        mem_rdata = '0;
        set_port(0, 32'h0000_5000, 1'b0, 2'b11, '0);
        set_port(1, 32'h0000_6000, 1'b0, 2'b11, '0);
        req_valid = 3'b011;
        sb.push_back('{port: 0, data: '0, err: 1'b1});
        settle();
        checks++;
        if (req_gnt !== 3'b001) begin
            failures++;
            $display("FAIL to_gnt0: got %b expected 001", req_gnt);
        end
        for (int k = 1; k <= TO; k++) begin
            tick();
            settle();
            checks++;
            if (k < TO) begin
                if ({res_valid, res_err, mem_valid} !== 5'b00001) begin
                    failures++;
                    $display("FAIL to_wait%0d: got rv=%b err=%b mv=%b expected 000/0/1",
                             k, res_valid, res_err, mem_valid);
                end
            end else if (sb.size() == 0) begin
                failures++;
                $display("FAIL to_abort: response with empty scoreboard");
            end else begin
                e = sb.pop_front();
                if ({res_valid, res_err, res_rdata} !== {3'b1 << e.port, e.err, e.data}) begin
                    failures++;
                    $display("FAIL to_abort: got rv=%b err=%b expected port %0d err=%b",
                             res_valid, res_err, e.port, e.err);
                end
            end
        end
        tick();
        req_valid = 3'b010;
        settle();
        checks++;
        if ({req_gnt, mem_valid} !== {3'b010, 1'b0}) begin
            failures++;
            $display("FAIL to_next_gnt: got gnt=%b mv=%b expected 010/0", req_gnt, mem_valid);
        end
        sb.push_back('{port: 1, data: d, err: 1'b0});
        for (int k = 1; k <= TO; k++) begin
            tick();
            if (k == TO) begin
                mem_ready = 1'b1; mem_rdata = d;
            end
            settle();
            checks++;
            if (k < TO) begin
                if (res_valid !== 3'b000) begin
                    failures++;
                    $display("FAIL to_wait2_%0d: got rv=%b expected 000", k, res_valid);
                end
            end else if (sb.size() == 0) begin
                failures++;
                $display("FAIL to_ready_wins: response with empty scoreboard");
            end else begin
                e = sb.pop_front();
                if ({res_valid, res_err, res_rdata} !== {3'b1 << e.port, e.err, e.data}) begin
                    failures++;
                    $display("FAIL to_ready_wins: got rv=%b err=%b data=%h expected port %0d err=0",
                             res_valid, res_err, res_rdata, e.port);
                end
            end
        end
        tick();
        mem_ready = 1'b0; req_valid = '0;
    endtask
`else
    task automatic test_timeout;
        logic [BW-1:0] d;
        do_reset();
        d = {4{32'h0BAD_F00D}};
        set_port(0, 32'h0000_5000, 1'b0, 2'b11, '0);
        req_valid = 3'b001;
        sb.push_back('{port: 0, data: d, err: 1'b0});
        settle();
        checks++;
        if (req_gnt !== 3'b001) begin
            failures++;
            $display("FAIL nto_gnt: got %b expected 001", req_gnt);
        end
        for (int k = 1; k <= 40; k++) begin
            tick();
            settle();
            checks++;
            if ({res_valid, res_err, mem_valid} !== 5'b00001) begin
                failures++;
                $display("FAIL nto_wait%0d: got rv=%b err=%b mv=%b expected 000/0/1",
                         k, res_valid, res_err, mem_valid);
            end
        end
        tick();
        mem_ready = 1'b1; mem_rdata = d;
        settle();
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL nto_rsp: response with empty scoreboard");
        end else begin
            e = sb.pop_front();
            if ({res_valid, res_err, res_rdata} !== {3'b1 << e.port, e.err, e.data}) begin
                failures++;
                $display("FAIL nto_rsp: got rv=%b err=%b data=%h expected port %0d",
                         res_valid, res_err, res_rdata, e.port);
            end
        end
        tick();
        mem_ready = 1'b0; req_valid = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_strobes();
        test_back_to_back();
        test_timeout();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d pending responses expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
